dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, is the number of 32-bit words in the backing array; it SHALL be a power of two.
REQ-002 Parameter LATENCY, default 2, is the number of wait cycles between request acceptance and response; its legal range SHALL be 0..7.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  is the reset: asynchronous and active-high.
REQ-005 Port req_valid_i  input  1  is the initiator request valid.
REQ-006 Port req_ready_o  output  1  indicates the responder can accept a request.
REQ-007 Port req_write_i  input  1  selects the access type: 1 = store, 0 = load.
REQ-008 Port req_addr_i  input  32  is the byte address.
REQ-009 Port req_wdata_i  input  32  is the store data.
REQ-010 Port req_be_i  input  4  holds the store byte enables; bit n enables wdata[8n+7:8n].
REQ-011 Port resp_valid_o  output  1  indicates a response is present.
REQ-012 Port resp_ready_i  input  1  indicates the initiator accepts the response.
REQ-013 Port resp_rdata_o  output  32  is the load data; it SHALL be 0 for stores and errors.
REQ-014 Port resp_err_o  output  1  flags a misaligned or out-of-range access.

Function
REQ-015 The FSM SHALL have three states (IDLE, WAIT, RESP) with these transitions:
- IDLE to WAIT on acceptance when LATENCY>0.
- IDLE to RESP on acceptance when LATENCY=0.
- WAIT to RESP when the wait counter reaches LATENCY-1.
- RESP to IDLE on the response handshake.
REQ-016 req_ready_o SHALL be 1 only in IDLE with rst deasserted; acceptance occurs at a rising edge where req_valid_i and req_ready_o are both 1.
REQ-017 At acceptance, the responder SHALL capture write, addr, wdata and be; input changes after acceptance SHALL have no effect on the transaction.
REQ-018 The wait counter SHALL be 3 bits, clear to 0 on acceptance, and increment once per WAIT cycle.
REQ-019 resp_valid_o SHALL first assert exactly LATENCY+1 cycles after the acceptance edge.
REQ-020 An access SHALL be an error if addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS; an error access SHALL neither read nor write the array.
REQ-021 A legal store SHALL update only the enabled bytes of word addr[31:2], on the edge entering RESP; be=4'b0000 SHALL complete as a legal no-op store.
REQ-022 A legal load SHALL register word addr[31:2] into resp_rdata_o on the edge entering RESP.
REQ-023 While resp_valid_o=1 and resp_ready_i=0, resp_rdata_o and resp_err_o SHALL hold stable.
REQ-024 After the response handshake, req_ready_o SHALL be 1 in the following cycle; a request and a response SHALL never be accepted in the same cycle.
REQ-025 req_valid_i during WAIT or RESP SHALL be ignored and not queued.
REQ-026 resp_ready_i while resp_valid_o=0 SHALL have no effect.
REQ-027 A load following a store to the same word SHALL return the post-store data.

Reset
REQ-028 While rst=1, the responder SHALL force state=IDLE, counter=0, req_ready_o=0, resp_valid_o=0, resp_rdata_o=0 and resp_err_o=0, asynchronously.
REQ-029 Reset asserted mid-transaction (WAIT or RESP) SHALL abort it; a store not yet committed SHALL NOT modify the array.
REQ-030 Array contents SHALL NOT be cleared by reset.

Verification
REQ-031 Store then load, LATENCY=2: store addr=0x10, wdata=0xDEADBEEF, be=4'hF; then load addr=0x10 -> each resp_valid_o rises 3 cycles after acceptance; load rdata=0xDEADBEEF, err=0.
REQ-032 Partial store: word 0x20 preloaded with 0x11223344; store be=4'b0101, wdata=0xAABBCCDD; load 0x20 -> rdata=0x11BB33DD.
REQ-033 Errors: load addr=0x22 -> err=1, rdata=0; store to addr=DEPTH_WORDS*4 -> err=1, and a subsequent load of word 0 is unchanged.
REQ-034 Backpressure: hold resp_ready_i=0 for 5 cycles after resp_valid_o -> rdata and err stable; req_valid_i pulses during this time are ignored; req_ready_o=1 the cycle after the handshake.
REQ-035 LATENCY=0: load accepted at edge N -> resp_valid_o=1 in cycle N+1; back-to-back requests complete at one transaction per 2 cycles with resp_ready_i=1.
REQ-036 Reset during WAIT of store addr=0x30, wdata=0x5 -> outputs zero immediately; after release, load 0x30 returns the pre-store value.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-port data memory responder with a valid/ready request channel and a
// valid/ready response channel. Each accepted request is held for LATENCY wait
// cycles, then the array access is performed on the edge entering RESP and the
// response is presented until the initiator accepts it.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [2:0]  LAST_CNT = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

  // state | meaning
  // IDLE  | ready for a request
  // WAIT  | request captured, counting wait cycles
  // RESP  | response presented, waiting for resp_ready_i
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic          mem_we;
  logic          txn_write;
  logic [31:0]   txn_addr;
  logic [31:0]   txn_wdata;
  logic [3:0]    txn_be;
  logic          txn_err;
  logic [AW-1:0] txn_idx;

  assign req_ready_o  = (state_q == S_IDLE) && !rst;
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign accept       = req_valid_i && req_ready_o;

  // Next-state, capture and response-register logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;

    // With LATENCY=0 the access happens on the acceptance edge itself, so the
    // transaction fields come straight from the inputs while in IDLE.
    if (state_q == S_IDLE) begin
      txn_write = req_write_i;
      txn_addr  = req_addr_i;
      txn_wdata = req_wdata_i;
      txn_be    = req_be_i;
    end else begin
      txn_write = write_q;
      txn_addr  = addr_q;
      txn_wdata = wdata_q;
      txn_be    = be_q;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d = req_write_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          be_d    = req_be_i;
          cnt_d   = 3'd0;
          if (LATENCY == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_CNT) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    txn_err = (txn_addr[1:0] != 2'b00) || ((txn_addr >> 2) >= 32'(DEPTH_WORDS));
    txn_idx = txn_addr[AW+1:2];

    if (enter_resp) begin
      err_d   = txn_err;
      rdata_d = (!txn_write && !txn_err) ? mem[txn_idx] : 32'd0;
    end

    mem_we = enter_resp && txn_write && !txn_err && !rst;
  end

  // Control and response registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Byte-enabled array write; contents survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && txn_be[b]) begin
        mem[txn_idx][8*b +: 8] <= txn_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 uses LATENCY=2, instance 1 LATENCY=0.
// Expected results come from a per-instance word-array model.
module tb_dmem_responder;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_be     [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  logic [31:0] model [2][DEPTH];
  int          checks   = 0;
  int          failures = 0;
  longint      cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_write_i(req_write[0]), .req_addr_i(req_addr[0]),
    .req_wdata_i(req_wdata[0]), .req_be_i(req_be[0]),
    .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
    .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_write_i(req_write[1]), .req_addr_i(req_addr[1]),
    .req_wdata_i(req_wdata[1]), .req_be_i(req_be[1]),
    .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
    .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit exp_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
  endfunction

  // Reference: apply one access to the model, return expected rdata/err.
  task automatic model_apply(input int d, input bit w, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] be,
                             output logic [31:0] rd, output logic er);
    er = exp_err(a);
    rd = 32'd0;
    if (!er) begin
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model[d][a >> 2][8*b +: 8] = wd[8*b +: 8];
      end else begin
        rd = model[d][a >> 2];
      end
    end
  endtask

  // Drives one transaction starting at a negedge with the DUT idle; returns the
  // observed response and the number of cycles from acceptance to resp_valid.
  task automatic txn(input int d, input bit w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be, input int stall,
                     output logic [31:0] rd, output logic er, output int lat);
    req_valid[d] = 1'b1;
    req_write[d] = w;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_be[d]    = be;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_write[d] = 1'($urandom);
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    req_be[d]    = 4'($urandom);
    lat = 1;
    while (!resp_valid[d] && lat < 20) begin
      resp_ready[d] = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata[d];
    er = resp_err[d];
    resp_ready[d] = 1'b0;
    repeat (stall) @(negedge clk);
    resp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b1; req_write[d] = 1'b1; req_addr[d] = 32'h0;
      req_wdata[d] = 32'h0; req_be[d] = 4'hF; resp_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b0 || resp_valid[d] !== 1'b0 ||
          resp_rdata[d] !== 32'd0 || resp_err[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs dut=%0d ready=%b valid=%b rdata=%h err=%b exp all zero",
                 d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
      end
      req_valid[d] = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_release dut=%0d ready=%b valid=%b exp ready=1 valid=0",
                 d, req_ready[d], resp_valid[d]);
      end
    end
  endtask

  task automatic test_fill();
    logic [31:0] rd, erd, wd;
    logic er, eer;
    int lat;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < DEPTH; i++) begin
        wd = $urandom;
        txn(d, 1'b1, 32'(i * 4), wd, 4'hF, 0, rd, er, lat);
        model_apply(d, 1'b1, 32'(i * 4), wd, 4'hF, erd, eer);
        checks++;
        if (rd !== erd || er !== eer || lat !== lat_of(d) + 1) begin
          failures++;
          $display("FAIL fill dut=%0d word=%0d rdata=%h err=%b lat=%0d exp rdata=%h err=%b lat=%0d",
                   d, i, rd, er, lat, erd, eer, lat_of(d) + 1);
        end
      end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    model_apply(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eer);
    checks++;
    if (rd !== 32'd0 || er !== 1'b0 || lat !== 3) begin
      failures++;
      $display("FAIL store_resp rdata=%h err=%b lat=%0d exp rdata=0 err=0 lat=3", rd, er, lat);
    end
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    model_apply(0, 1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 3) begin
      failures++;
      $display("FAIL load_after_store rdata=%h err=%b lat=%0d exp rdata=deadbeef err=0 lat=3",
               rd, er, lat);
    end
  endtask

  task automatic test_partial_store();
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat);
    model_apply(0, 1'b1, 32'h20, 32'h11223344, 4'hF, erd, eer);
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat);
    model_apply(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, erd, eer);
    txn(0, 1'b1, 32'h20, 32'h99999999, 4'b0000, 0, rd, er, lat);
    model_apply(0, 1'b1, 32'h20, 32'h99999999, 4'b0000, erd, eer);
    checks++;
    if (er !== 1'b0) begin
      failures++;
      $display("FAIL be_zero_store err=%b exp 0", er);
    end
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
    checks++;
    if (rd !== 32'h11BB33DD || er !== 1'b0) begin
      failures++;
      $display("FAIL partial_store rdata=%h err=%b exp rdata=11bb33dd err=0", rd, er);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    txn(0, 1'b0, 32'h22, 32'h0, 4'h0, 0, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b1) begin
      failures++;
      $display("FAIL misaligned_load rdata=%h err=%b exp rdata=0 err=1", rd, er);
    end
    txn(0, 1'b1, 32'(DEPTH * 4), 32'hCAFEF00D, 4'hF, 0, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b1) begin
      failures++;
      $display("FAIL range_store rdata=%h err=%b exp rdata=0 err=1", rd, er);
    end
    txn(0, 1'b1, 32'h0000_0101, 32'hCAFEF00D, 4'hF, 0, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin
      failures++;
      $display("FAIL misaligned_store err=%b exp 1", er);
    end
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat);
    model_apply(0, 1'b0, 32'h0, 32'h0, 4'h0, erd, eer);
    checks++;
    if (rd !== erd || er !== 1'b0) begin
      failures++;
      $display("FAIL word0_after_err rdata=%h err=%b exp rdata=%h err=0", rd, er, erd);
    end
    txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 0, rd, er, lat);
    model_apply(0, 1'b0, 32'h4, 32'h0, 4'h0, erd, eer);
    checks++;
    if (rd !== erd || er !== 1'b0) begin
      failures++;
      $display("FAIL word1_after_err rdata=%h err=%b exp rdata=%h err=0", rd, er, erd);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, erd, rd;
    logic eer, er;
    int n, lat;
    a = 32'(($urandom % DEPTH) * 4);
    model_apply(0, 1'b0, a, 32'h0, 4'h0, erd, eer);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = a;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 1;
    while (!resp_valid[0] && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL bp_latency cycles=%0d exp 3", n);
    end
    for (int i = 0; i < 5; i++) begin
      resp_ready[0] = 1'b0;
      req_valid[0]  = 1'(i % 2);
      req_write[0]  = 1'b1;
      req_addr[0]   = a;
      req_wdata[0]  = ~erd;
      req_be[0]     = 4'hF;
      @(negedge clk);
      checks++;
      if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== erd || resp_err[0] !== eer ||
          req_ready[0] !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d valid=%b rdata=%h err=%b ready=%b exp valid=1 rdata=%h err=%b ready=0",
                 i, resp_valid[0], resp_rdata[0], resp_err[0], req_ready[0], erd, eer);
      end
    end
    req_valid[0]  = 1'b0;
    resp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[0] = 1'b0;
    checks++;
    if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_after_handshake ready=%b valid=%b exp ready=1 valid=0",
               req_ready[0], resp_valid[0]);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL bp_not_queued valid=%b ready=%b exp valid=0 ready=1",
               resp_valid[0], req_ready[0]);
    end
    txn(0, 1'b0, a, 32'h0, 4'h0, 0, rd, er, lat);
    checks++;
    if (rd !== erd || er !== 1'b0) begin
      failures++;
      $display("FAIL bp_ignored_store rdata=%h err=%b exp rdata=%h err=0", rd, er, erd);
    end
  endtask

  task automatic test_latency0();
    logic [31:0] rd, erd, a, wd;
    logic er, eer, w;
    int lat;
    longint t0;
    a = 32'(($urandom % DEPTH) * 4);
    txn(1, 1'b0, a, 32'h0, 4'h0, 0, rd, er, lat);
    model_apply(1, 1'b0, a, 32'h0, 4'h0, erd, eer);
    checks++;
    if (lat !== 1 || rd !== erd || er !== 1'b0) begin
      failures++;
      $display("FAIL lat0_load lat=%0d rdata=%h err=%b exp lat=1 rdata=%h err=0", lat, rd, er, erd);
    end
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      w  = 1'($urandom);
      a  = 32'(($urandom % (DEPTH + 4)) * 4);
      wd = $urandom;
      txn(1, w, a, wd, 4'hF, 0, rd, er, lat);
      model_apply(1, w, a, wd, 4'hF, erd, eer);
      checks++;
      if (lat !== 1 || rd !== erd || er !== eer) begin
        failures++;
        $display("FAIL lat0_b2b i=%0d lat=%0d rdata=%h err=%b exp lat=1 rdata=%h err=%b",
                 i, lat, rd, er, erd, eer);
      end
    end
    checks++;
    if (cyc - t0 !== 64'd32) begin
      failures++;
      $display("FAIL lat0_throughput cycles=%0d exp 32", cyc - t0);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, wd;
    logic [3:0] be;
    logic er, eer, w;
    int d, lat, kind;
    for (int i = 0; i < 60; i++) begin
      d    = int'($urandom_range(0, 1));
      w    = 1'($urandom);
      kind = int'($urandom_range(0, 9));
      if (kind < 7)       a = 32'(($urandom % DEPTH) * 4);
      else if (kind == 7) a = 32'(($urandom % DEPTH) * 4 + $urandom_range(1, 3));
      else                a = 32'(DEPTH * 4 + ($urandom % 256) * 4);
      wd = $urandom;
      be = 4'($urandom);
      txn(d, w, a, wd, be, int'($urandom_range(0, 3)), rd, er, lat);
      model_apply(d, w, a, wd, be, erd, eer);
      checks++;
      if (rd !== erd || er !== eer || lat !== lat_of(d) + 1) begin
        failures++;
        $display("FAIL random i=%0d dut=%0d w=%b a=%h rdata=%h err=%b lat=%0d exp rdata=%h err=%b lat=%0d",
                 i, d, w, a, rd, er, lat, erd, eer, lat_of(d) + 1);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, erd, a;
    logic er, eer;
    int lat, n;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h30;
    req_wdata[0] = 32'h5; req_be[0] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready[0] !== 1'b0 || resp_valid[0] !== 1'b0 ||
        resp_rdata[0] !== 32'd0 || resp_err[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort_wait_outputs ready=%b valid=%b rdata=%h err=%b exp all zero",
               req_ready[0], resp_valid[0], resp_rdata[0], resp_err[0]);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort_release ready=%b valid=%b exp ready=1 valid=0",
               req_ready[0], resp_valid[0]);
    end
    txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er, lat);
    model_apply(0, 1'b0, 32'h30, 32'h0, 4'h0, erd, eer);
    checks++;
    if (rd !== erd || er !== 1'b0) begin
      failures++;
      $display("FAIL abort_store_dropped rdata=%h err=%b exp rdata=%h err=0", rd, er, erd);
    end
    // Reset while a load response is being held.
    a = 32'h34;
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = a;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 1;
    while (!resp_valid[0] && n < 20) begin @(negedge clk); n++; end
    rst = 1'b1;
    #1;
    checks++;
    if (resp_valid[0] !== 1'b0 || resp_rdata[0] !== 32'd0 || resp_err[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort_resp_outputs valid=%b rdata=%h err=%b exp all zero",
               resp_valid[0], resp_rdata[0], resp_err[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    txn(0, 1'b0, a, 32'h0, 4'h0, 0, rd, er, lat);
    model_apply(0, 1'b0, a, 32'h0, 4'h0, erd, eer);
    checks++;
    if (rd !== erd || er !== 1'b0) begin
      failures++;
      $display("FAIL array_survives_reset rdata=%h err=%b exp rdata=%h err=0", rd, er, erd);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_store_load();
    test_partial_store();
    test_errors();
    test_backpressure();
    test_latency0();
    test_random();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
